mem_responder: RTL
==================

# mem_responder

Unified instruction/data memory that answers the multicycle MIPS core's memory interface. It selects the address between `pc` and `dataaddr` using `iord`. It performs writes on `memwrite` and returns a registered read word. It holds the instruction register loaded on `irwrite`. It sits beside the core at CPU top level and adds fault detection and a fetch counter for the bench.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 32-bit words; must be a power of two, at least 4.
- `INIT_FILE`, "": hex image loaded into the array at time zero; an empty string means no load.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous and active-low; asserting it (0) clears all registers immediately.
- `memwrite`  in  1  write strobe for the current cycle.
- `iord`  in  1  address select: 0 selects `pc`, 1 selects `dataaddr`.
- `irwrite`  in  1  load the instruction register.
- `pc`  in  32  fetch byte address.
- `dataaddr`  in  32  data byte address (core ALU output).
- `writedata`  in  32  store data.
- `instr`  out  32  instruction register.
- `readdata`  out  32  registered read data.
- `fault`  out  1  sticky access fault.
- `fault_addr`  out  32  byte address of the first faulting access.
- `fetch_count`  out  32  number of `irwrite` cycles since reset.

## Operation
- Selected address: `addr = iord ? dataaddr : pc`. Word index is `addr[log2(DEPTH_WORDS)+1:2]`.
- An access is valid when `addr[1:0]==0` and `addr < 4*DEPTH_WORDS`. Otherwise it is a fault.
- Read happens every cycle: `readdata <= mem[index]` for a valid address, otherwise `readdata <= 0`.
- Write: when `memwrite=1` and the address is valid, `mem[index] <= writedata`. A write to a faulting address is dropped and the array is unchanged.
- Write forwarding: a read of the word being written in the same cycle returns the new `writedata`. Write-first semantics apply.
- Instruction register:
  - When `irwrite=1`, `instr` is loaded from the same word that `readdata` gets, including forwarding.
  - Otherwise `instr` holds its value.
  - `fetch_count` increments on every `irwrite` cycle and wraps from 0xFFFFFFFF to 0.
- Fault handling:
  - A fault is recorded only in a cycle with `memwrite | irwrite | iord`. Idle cycles with a junk `pc` are not faults.
  - On the first recorded fault, `fault <= 1` and `fault_addr <= addr`.
  - Later faults leave both unchanged. Only reset clears them.
- Memory array:
  - The array is not reset.
  - Contents persist across reset.
  - `INIT_FILE` is applied once, at time zero.

## Timing
- Read latency is 1 cycle: the address presented in cycle N appears on `readdata` after the edge ending cycle N. This matches the core's MemRead → register-read step.
- A write commits at the edge ending the cycle in which `memwrite` is high. A read of that word in cycle N+1 sees the new data.
- `instr` updates at the same edge as `readdata` when `irwrite=1`.
- `irwrite` and `memwrite` high together: the write commits and `instr` gets the forwarded `writedata` when the addresses match.
- Reset asserted mid-cycle:
  - Outputs go to reset values immediately.
  - A write in that cycle is not committed while `reset=0`.
  - The first update happens at the first rising edge after release.
- Reset values: `instr=0`, `readdata=0`, `fault=0`, `fault_addr=0`, `fetch_count=0`.

## Configuration
- `MEM_TRACE_EN` defined: at each rising edge with `memwrite | irwrite`, the block prints one line carrying time, `memwrite`, `iord`, `irwrite`, `addr`, `writedata` and the word read. A fault prints an extra line flagged `FAULT`. The trace is simulation-only.
- `MEM_TRACE_EN` undefined: no display statements are compiled. Functional behaviour is identical.

## Test plan
- Reset then release with `INIT_FILE` holding word0=0x20080005. `iord=0`, `pc=0`, `irwrite=1` for 1 cycle → `instr=0x20080005`, `readdata=0x20080005`, `fetch_count=1`.
- `iord=1`, `dataaddr=0x10`, `writedata=0xDEADBEEF`, `memwrite=1` for 1 cycle, then a read of 0x10 → next-cycle `readdata=0xDEADBEEF`. A same-cycle write+read of 0x10 also returns 0xDEADBEEF.
- With `DEPTH_WORDS=256`, write 0x12345678 to `dataaddr=0x400` (out of range) → array unchanged, `readdata=0`, `fault=1`, `fault_addr=0x400`. A later misaligned access at 0x13 leaves `fault_addr=0x400`.
- `irwrite=0` for 3 cycles while memory changes under `pc` → `instr` holds its value and `fetch_count` is unchanged.
- Assert `reset=0` mid-cycle during a `memwrite` to 0x20 → outputs clear immediately, the word at 0x20 keeps its old value, and previously written 0x10 still reads 0xDEADBEEF after release.
- Preload `fetch_count` to 0xFFFFFFFF through 2^32−1 forced increments (or a bench `force`), then one more `irwrite` → `fetch_count=0`.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: unified instruction/data memory for a multicycle MIPS core.
// It has one selected address per cycle, 1-cycle registered reads, write-first
// forwarding, an instruction register, a sticky access-fault record and a
// fetch counter.
// Optional build macro: MEM_TRACE_EN adds a simulation-only access trace.
module mem_responder #(
  parameter int    DEPTH_WORDS = 256,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        iord,
  input  logic        irwrite,
  input  logic [31:0] pc,
  input  logic [31:0] dataaddr,
  input  logic [31:0] writedata,
  output logic [31:0] instr,
  output logic [31:0] readdata,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   addr;
  logic [AW-1:0] index;
  logic          valid;
  logic          access;
  logic          wr_en;
  logic [31:0]   rd_word;

  // Select the address, check alignment and range, and build the read word.
  // The write-first forward means the read sees this cycle's store.
  // NOTE: this block is combinational, so it uses blocking assignments and
  // assigns every output on every path. That prevents inferred latches.
  always_comb begin
    addr    = iord ? dataaddr : pc;
    index   = addr[AW+1:2];
    valid   = (addr[1:0] == 2'b00) && ((addr >> (AW + 2)) == 32'd0);
    access  = memwrite | irwrite | iord;
    wr_en   = memwrite & valid;
    rd_word = 32'd0;
    if (valid) rd_word = wr_en ? writedata : mem[index];
  end

  // Storage array. A write is committed only while reset is released.
  // NOTE: the array has no reset branch. Its contents must survive reset, and
  // a reset on the array would prevent the tools from mapping it to block RAM.
  always_ff @(posedge clk) begin
    if (reset && wr_en) mem[index] <= writedata;
  end

  // Registered read data, instruction register, fetch counter and the sticky
  // first-fault capture.
  // NOTE: sequential state is updated with non-blocking assignments. Every
  // register then samples values from before the edge, whatever the order of
  // the statements.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata    <= 32'd0;
      instr       <= 32'd0;
      fetch_count <= 32'd0;
      fault       <= 1'b0;
      fault_addr  <= 32'd0;
    end else begin
      readdata <= rd_word;
      if (irwrite) begin
        instr       <= rd_word;
        fetch_count <= fetch_count + 32'd1;
      end
      if (access && !valid && !fault) begin
        fault      <= 1'b1;
        fault_addr <= addr;
      end
    end
  end

`ifdef MEM_TRACE_EN
  // Simulation-only trace of strobed accesses, with a flagged line for faults.
  always @(posedge clk) begin
    if (reset && (memwrite || irwrite)) begin
      $display("%0t mem: memwrite=%0b iord=%0b irwrite=%0b addr=%08h wdata=%08h rdata=%08h",
               $time, memwrite, iord, irwrite, addr, writedata, rd_word);
      if (!valid) $display("%0t mem: FAULT addr=%08h", $time, addr);
    end
  end
`else
  // No trace logic is built when the trace is disabled.
`endif

endmodule
